bram_dp: RTL

Parametrised dual-port block RAM: the next generation of the single-port `bram`. Port A is read/write with per-byte write enables and a selectable read-during-write mode. Port B is read-only. Both ports have an optional output pipeline register. A built-in clear sequencer fills the array with a constant after reset or on request, so frame buffers and lookup tables start from a known state.

---
 rtl/bram_pkg.sv | 15 +
 rtl/bram_clear_seq.sv | 50 +++++
 rtl/bram_dp.sv | 127 ++++++++++++
 3 files changed

// File: rtl/bram_pkg.sv
// bram_pkg: shared constants, clear-FSM state type and lane-count helper for bram_dp
package bram_pkg;
    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;
    localparam int RDW_NO_CHANGE   = 2;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } clr_state_e;

    function automatic int calc_nb(input int width, input int byte_width);
        return width / byte_width;
    endfunction
endpackage

// File: rtl/bram_clear_seq.sv
// bram_clear_seq: walks every address once after reset or on request, emitting clear writes
module bram_clear_seq
    import bram_pkg::*;
#(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 clear_request,
    output logic                 busy,
    output logic                 clear_write,
    output logic [ADDR_BITS-1:0] clear_address
);
    clr_state_e           state_q, state_d;
    logic [ADDR_BITS-1:0] cnt_q, cnt_d;
    logic                 start_q, start_d;

    // start_q forces one clear on the first edge after reset; requests during CLEAR are ignored
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start_d = 1'b0;
        if (state_q == ST_IDLE) begin
            if (start_q || clear_request) begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == '1) ? ST_IDLE : ST_CLEAR;
        end
    end

    // sequencer state; reset aborts any clear in progress and rearms the start flag
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            start_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
        end
    end

    assign busy          = (state_q == ST_CLEAR);
    assign clear_write   = busy;
    assign clear_address = cnt_q;
endmodule

// File: rtl/bram_dp.sv
// bram_dp: dual-port block RAM, port A byte-lane read/write, port B read-only, built-in clear
module bram_dp
    import bram_pkg::*;
#(
    parameter int                   RAM_WIDTH     = 8,
    parameter int                   RAM_ADDR_BITS = 10,
    parameter int                   BYTE_WIDTH    = 8,
    parameter int                   RDW_MODE      = 0,
    parameter int                   OUTPUT_REG    = 0,
    parameter logic [RAM_WIDTH-1:0] CLEAR_VALUE   = '0,
    localparam int                  NB            = calc_nb(RAM_WIDTH, BYTE_WIDTH)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     clear_request,
    output logic                     busy,
    input  logic                     a_enable,
    input  logic [NB-1:0]            a_write_enable,
    input  logic [RAM_ADDR_BITS-1:0] a_address,
    input  logic [RAM_WIDTH-1:0]     a_input_data,
    output logic [RAM_WIDTH-1:0]     a_output_data,
    output logic                     a_valid,
    input  logic                     b_enable,
    input  logic [RAM_ADDR_BITS-1:0] b_address,
    output logic [RAM_WIDTH-1:0]     b_output_data,
    output logic                     b_valid
);
    if ((RAM_WIDTH % BYTE_WIDTH) != 0 || RDW_MODE > 2) begin : g_bad_params
        $fatal(1, "bram_dp: RAM_WIDTH must be a multiple of BYTE_WIDTH and RDW_MODE <= 2");
    end

    logic [RAM_WIDTH-1:0]     mem [2**RAM_ADDR_BITS];
    logic                     clr_we;
    logic [RAM_ADDR_BITS-1:0] clr_addr;
    logic                     a_acc, b_acc, a_wr;
    logic [NB-1:0]            wr_lane;
    logic [RAM_ADDR_BITS-1:0] wr_addr;
    logic [RAM_WIDTH-1:0]     wr_data, a_old, b_old, a_merged;
    logic [RAM_WIDTH-1:0]     a_data1_q, a_data1_d, b_data1_q, b_data1_d;
    logic                     a_valid1_q, a_valid1_d, b_valid1_q, b_valid1_d;

    bram_clear_seq #(.ADDR_BITS(RAM_ADDR_BITS)) u_clear_seq (
        .clock         (clock),
        .reset_n       (reset_n),
        .clear_request (clear_request),
        .busy          (busy),
        .clear_write   (clr_we),
        .clear_address (clr_addr)
    );

    assign a_acc   = a_enable && !busy;
    assign b_acc   = b_enable && !busy;
    assign a_wr    = a_acc && (a_write_enable != '0);
    assign wr_lane = clr_we ? '1 : (a_acc ? a_write_enable : '0);
    assign wr_addr = clr_we ? clr_addr : a_address;
    assign wr_data = clr_we ? CLEAR_VALUE : a_input_data;

    // old words at both addresses and the lane-merged word port A would store
    always_comb begin
        a_old    = mem[a_address];
        b_old    = mem[b_address];
        a_merged = a_old;
        for (int i = 0; i < NB; i++)
            if (a_write_enable[i]) a_merged[i*BYTE_WIDTH +: BYTE_WIDTH] = a_input_data[i*BYTE_WIDTH +: BYTE_WIDTH];
    end

    // shared write path: clear sequencer owns it while busy, port A otherwise
    always_ff @(posedge clock) begin
        for (int i = 0; i < NB; i++)
            if (wr_lane[i]) mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
    end

    // first read stage; data holds when not updated, NO_CHANGE writes suppress the A result
    always_comb begin
        a_data1_d  = a_data1_q;
        a_valid1_d = 1'b0;
        b_data1_d  = b_acc ? b_old : b_data1_q;
        b_valid1_d = b_acc;
        if (a_acc && !(a_wr && RDW_MODE == RDW_NO_CHANGE)) begin
            a_valid1_d = 1'b1;
            a_data1_d  = (a_wr && RDW_MODE == RDW_WRITE_FIRST) ? a_merged : a_old;
        end
    end

    // first-stage output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_data1_q  <= '0;
            a_valid1_q <= 1'b0;
            b_data1_q  <= '0;
            b_valid1_q <= 1'b0;
        end else begin
            a_data1_q  <= a_data1_d;
            a_valid1_q <= a_valid1_d;
            b_data1_q  <= b_data1_d;
            b_valid1_q <= b_valid1_d;
        end
    end

    if (OUTPUT_REG != 0) begin : g_oreg
        logic [RAM_WIDTH-1:0] a_data2_q, b_data2_q;
        logic                 a_valid2_q, b_valid2_q;
        // optional second stage; valid travels with its data
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                a_data2_q  <= '0;
                a_valid2_q <= 1'b0;
                b_data2_q  <= '0;
                b_valid2_q <= 1'b0;
            end else begin
                a_data2_q  <= a_data1_q;
                a_valid2_q <= a_valid1_q;
                b_data2_q  <= b_data1_q;
                b_valid2_q <= b_valid1_q;
            end
        end
        assign a_output_data = a_data2_q;
        assign a_valid       = a_valid2_q;
        assign b_output_data = b_data2_q;
        assign b_valid       = b_valid2_q;
    end else begin : g_noreg
        assign a_output_data = a_data1_q;
        assign a_valid       = a_valid1_q;
        assign b_output_data = b_data1_q;
        assign b_valid       = b_valid1_q;
    end
endmodule
